// File: rtl/fsld_seq_ctrl.sv
// Sequencer for the first-stage load: walks the kernel, bias and input-feature write phases in order.
// Latency: a phase is entered the cycle after its trigger (accepted start or matching done); outputs are registered.
// Backpressure: none; FIFO handshake is only monitored to count beats, and the master state can abort at any time.
module fsld_seq_ctrl #(
  parameter int CNT_BITS      = 16,
  parameter int MAST_FSM_BITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [MAST_FSM_BITS-1:0] mast_current_state,
  input  logic                     fsld_start,
  input  logic [CNT_BITS-1:0]      cfg_ker_words,
  input  logic [CNT_BITS-1:0]      cfg_bias_words,
  input  logic [CNT_BITS-1:0]      cfg_if_words,
  input  logic                     ker_write_done,
  input  logic                     bias_write_done,
  input  logic                     if_write_done,
  input  logic                     empty_n_from_gi,
  input  logic                     read_for_gi,
  output logic [MAST_FSM_BITS-1:0] fsld_current_state,
  output logic                     ker_write_busy,
  output logic                     bias_write_busy,
  output logic                     if_write_busy,
  output logic                     ker_write_start,
  output logic                     bias_write_start,
  output logic                     if_write_start,
  output logic                     fsld_done,
  output logic [CNT_BITS-1:0]      beat_cnt,
  output logic                     cnt_err
);

  typedef enum logic [2:0] {
    FS_IDLE = 3'd0,
    FS_KER  = 3'd1,
    FS_BIAS = 3'd2,
    FS_IF   = 3'd3,
    FS_DONE = 3'd4
  } state_t;

  localparam logic [MAST_FSM_BITS-1:0] MAST_FSLD = MAST_FSM_BITS'(7);

  state_t                state_q, state_d;
  logic                  ker_start_q, bias_start_q, if_start_q;
  logic                  ker_start_d, bias_start_d, if_start_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [CNT_BITS-1:0]   ker_words_q, bias_words_q, if_words_q;

  logic                  in_fsld;
  logic                  accept;
  logic                  in_phase;
  logic                  beat;
  logic [CNT_BITS-1:0]   final_cnt;
  logic                  phase_done;
  logic [CNT_BITS-1:0]   phase_words;

  assign in_fsld  = (mast_current_state == MAST_FSLD);
  assign accept   = (state_q == FS_IDLE) && in_fsld && fsld_start;
  assign in_phase = (state_q == FS_KER) || (state_q == FS_BIAS) || (state_q == FS_IF);
  assign beat     = in_phase && empty_n_from_gi && read_for_gi;
  // A beat landing together with done is included before the count is judged.
  assign final_cnt = (beat && !(&cnt_q)) ? cnt_q + CNT_BITS'(1) : cnt_q;

  // Next state, launch pulses, beat counter and error flag.
  always_comb begin
    state_d     = state_q;
    phase_done  = 1'b0;
    phase_words = '0;
    case (state_q)
      FS_IDLE: begin
        if (accept) begin
          if (cfg_ker_words != '0)       state_d = FS_KER;
          else if (cfg_bias_words != '0) state_d = FS_BIAS;
          else if (cfg_if_words != '0)   state_d = FS_IF;
          else                           state_d = FS_DONE;
        end
      end
      FS_KER: begin
        phase_words = ker_words_q;
        // Abort outranks a simultaneous done.
        if (!in_fsld) state_d = FS_IDLE;
        else if (ker_write_done) begin
          phase_done = 1'b1;
          if (bias_words_q != '0)      state_d = FS_BIAS;
          else if (if_words_q != '0)   state_d = FS_IF;
          else                         state_d = FS_DONE;
        end
      end
      FS_BIAS: begin
        phase_words = bias_words_q;
        if (!in_fsld) state_d = FS_IDLE;
        else if (bias_write_done) begin
          phase_done = 1'b1;
          state_d    = (if_words_q != '0) ? FS_IF : FS_DONE;
        end
      end
      FS_IF: begin
        phase_words = if_words_q;
        if (!in_fsld) state_d = FS_IDLE;
        else if (if_write_done) begin
          phase_done = 1'b1;
          state_d    = FS_DONE;
        end
      end
      FS_DONE: state_d = FS_IDLE;
      default: state_d = FS_IDLE;
    endcase

    ker_start_d  = (state_d == FS_KER)  && (state_q != FS_KER);
    bias_start_d = (state_d == FS_BIAS) && (state_q != FS_BIAS);
    if_start_d   = (state_d == FS_IF)   && (state_q != FS_IF);

    // Counter restarts on every phase entry and stays cleared outside phases.
    cnt_d = (in_phase && (state_d == state_q)) ? final_cnt : '0;

    err_d = err_q;
    if (accept)                                       err_d = 1'b0;
    else if (phase_done && (final_cnt != phase_words)) err_d = 1'b1;
  end

  // State, pulse, counter, flag and latched-config registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FS_IDLE;
      ker_start_q  <= 1'b0;
      bias_start_q <= 1'b0;
      if_start_q   <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      ker_words_q  <= '0;
      bias_words_q <= '0;
      if_words_q   <= '0;
    end else begin
      state_q      <= state_d;
      ker_start_q  <= ker_start_d;
      bias_start_q <= bias_start_d;
      if_start_q   <= if_start_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      if (accept) begin
        ker_words_q  <= cfg_ker_words;
        bias_words_q <= cfg_bias_words;
        if_words_q   <= cfg_if_words;
      end
    end
  end

  assign fsld_current_state = MAST_FSM_BITS'(state_q);
  assign ker_write_busy     = (state_q == FS_KER);
  assign bias_write_busy    = (state_q == FS_BIAS);
  assign if_write_busy      = (state_q == FS_IF);
  assign ker_write_start    = ker_start_q;
  assign bias_write_start   = bias_start_q;
  assign if_write_start     = if_start_q;
  assign fsld_done          = (state_q == FS_DONE);
  assign beat_cnt           = cnt_q;
  assign cnt_err            = err_q;

endmodule

// File: tb/tb_fsld_seq_ctrl.sv
// Directed vector bench for fsld_seq_ctrl.
// Each row: inputs driven on the falling edge, outputs checked 1 time unit after the next rising edge.
// Rows carry hand-computed expected state, pulses, beat count and error flag.
module tb_fsld_seq_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  mast_current_state;
  logic        fsld_start;
  logic [15:0] cfg_ker_words, cfg_bias_words, cfg_if_words;
  logic        ker_write_done, bias_write_done, if_write_done;
  logic        empty_n_from_gi, read_for_gi;
  logic [2:0]  fsld_current_state;
  logic        ker_write_busy, bias_write_busy, if_write_busy;
  logic        ker_write_start, bias_write_start, if_write_start;
  logic        fsld_done;
  logic [15:0] beat_cnt;
  logic        cnt_err;

  fsld_seq_ctrl dut (
    .clk(clk), .reset(reset), .mast_current_state(mast_current_state), .fsld_start(fsld_start),
    .cfg_ker_words(cfg_ker_words), .cfg_bias_words(cfg_bias_words), .cfg_if_words(cfg_if_words),
    .ker_write_done(ker_write_done), .bias_write_done(bias_write_done), .if_write_done(if_write_done),
    .empty_n_from_gi(empty_n_from_gi), .read_for_gi(read_for_gi),
    .fsld_current_state(fsld_current_state),
    .ker_write_busy(ker_write_busy), .bias_write_busy(bias_write_busy), .if_write_busy(if_write_busy),
    .ker_write_start(ker_write_start), .bias_write_start(bias_write_start), .if_write_start(if_write_start),
    .fsld_done(fsld_done), .beat_cnt(beat_cnt), .cnt_err(cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  mast;
    logic        go;
    logic [2:0]  dn;     // {ker, bias, if}
    logic        bt;
    logic [15:0] ck, cb, ci;
    logic [2:0]  est;
    logic [2:0]  estrt;  // {ker, bias, if}
    logic        edn;
    logic [15:0] ebc;
    logic        eerr;
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   vidx   = 0;

  function automatic vec_t mk(input logic rst, input logic [2:0] mast, input logic go, input logic [2:0] dn,
                              input logic bt, input logic [15:0] ck, input logic [15:0] cb, input logic [15:0] ci,
                              input logic [2:0] est, input logic [2:0] estrt, input logic edn,
                              input logic [15:0] ebc, input logic eerr);
    vec_t v;
    v.rst = rst; v.mast = mast; v.go = go; v.dn = dn; v.bt = bt;
    v.ck = ck; v.cb = cb; v.ci = ci;
    v.est = est; v.estrt = estrt; v.edn = edn; v.ebc = ebc; v.eerr = eerr;
    return v;
  endfunction

  task automatic add(input logic rst, input logic [2:0] mast, input logic go, input logic [2:0] dn,
                     input logic bt, input logic [15:0] ck, input logic [15:0] cb, input logic [15:0] ci,
                     input logic [2:0] est, input logic [2:0] estrt, input logic edn,
                     input logic [15:0] ebc, input logic eerr);
    vq.push_back(mk(rst, mast, go, dn, bt, ck, cb, ci, est, estrt, edn, ebc, eerr));
  endtask

  task automatic apply(input vec_t v);
    logic [2:0] ebusy;
    @(negedge clk);
    reset = v.rst; mast_current_state = v.mast; fsld_start = v.go;
    {ker_write_done, bias_write_done, if_write_done} = v.dn;
    empty_n_from_gi = v.bt; read_for_gi = v.bt;
    cfg_ker_words = v.ck; cfg_bias_words = v.cb; cfg_if_words = v.ci;
    @(posedge clk);
    #1;
    ebusy = {v.est == 3'd1, v.est == 3'd2, v.est == 3'd3};
    n_cmp++;
    if (fsld_current_state !== v.est ||
        {ker_write_busy, bias_write_busy, if_write_busy} !== ebusy ||
        {ker_write_start, bias_write_start, if_write_start} !== v.estrt ||
        fsld_done !== v.edn || beat_cnt !== v.ebc || cnt_err !== v.eerr) begin
      n_fail++;
      $display("FAIL vec%0d: got st=%0d busy=%b start=%b done=%b bc=%0d err=%b, want st=%0d busy=%b start=%b done=%b bc=%0d err=%b",
               vidx, fsld_current_state, {ker_write_busy, bias_write_busy, if_write_busy},
               {ker_write_start, bias_write_start, if_write_start}, fsld_done, beat_cnt, cnt_err,
               v.est, ebusy, v.estrt, v.edn, v.ebc, v.eerr);
    end
    vidx++;
  endtask

  initial begin
    reset = 1'b0; mast_current_state = 3'd0; fsld_start = 1'b0;
    ker_write_done = 1'b0; bias_write_done = 1'b0; if_write_done = 1'b0;
    empty_n_from_gi = 1'b0; read_for_gi = 1'b0;
    cfg_ker_words = '0; cfg_bias_words = '0; cfg_if_words = '0;

    // Reset state.
    add(0, 7, 0, 3'b000, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0);
    add(0, 7, 1, 3'b000, 1, 4, 2, 8,  0, 3'b000, 0, 0, 0);

    // Full load 4/2/8; cfg goes to zero after accept to show it was latched.
    add(1, 7, 1, 3'b000, 0, 4, 2, 8,  1, 3'b100, 0, 0, 0);
    for (int n = 0; n < 4; n++) add(1, 7, 0, 3'b000, 1, 0, 0, 0,  1, 3'b000, 0, 16'(n + 1), 0);
    add(1, 7, 0, 3'b100, 0, 0, 0, 0,  2, 3'b010, 0, 0, 0);
    add(1, 7, 0, 3'b000, 1, 0, 0, 0,  2, 3'b000, 0, 1, 0);
    add(1, 7, 0, 3'b010, 1, 0, 0, 0,  3, 3'b001, 0, 0, 0);   // beat with done counts
    for (int n = 0; n < 8; n++) add(1, 7, 0, 3'b000, 1, 0, 0, 0,  3, 3'b000, 0, 16'(n + 1), 0);
    add(1, 7, 0, 3'b001, 0, 0, 0, 0,  4, 3'b000, 1, 0, 0);
    add(1, 7, 0, 3'b000, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0);

    // Zero bias words: KER straight to IF.
    add(1, 7, 1, 3'b000, 0, 3, 0, 2,  1, 3'b100, 0, 0, 0);
    for (int n = 0; n < 3; n++) add(1, 7, 0, 3'b000, 1, 3, 0, 2,  1, 3'b000, 0, 16'(n + 1), 0);
    add(1, 7, 0, 3'b100, 0, 3, 0, 2,  3, 3'b001, 0, 0, 0);
    for (int n = 0; n < 2; n++) add(1, 7, 0, 3'b000, 1, 3, 0, 2,  3, 3'b000, 0, 16'(n + 1), 0);
    add(1, 7, 0, 3'b001, 0, 3, 0, 2,  4, 3'b000, 1, 0, 0);
    add(1, 7, 0, 3'b000, 0, 3, 0, 2,  0, 3'b000, 0, 0, 0);

    // Short kernel count sets sticky error; cleared only by next accepted start (all-zero cfg -> DONE).
    add(1, 7, 1, 3'b000, 0, 4, 1, 0,  1, 3'b100, 0, 0, 0);
    for (int n = 0; n < 3; n++) add(1, 7, 0, 3'b000, 1, 4, 1, 0,  1, 3'b000, 0, 16'(n + 1), 0);
    add(1, 7, 0, 3'b100, 0, 4, 1, 0,  2, 3'b010, 0, 0, 1);
    add(1, 7, 0, 3'b000, 1, 4, 1, 0,  2, 3'b000, 0, 1, 1);
    add(1, 7, 0, 3'b010, 0, 4, 1, 0,  4, 3'b000, 1, 0, 1);
    add(1, 7, 0, 3'b000, 0, 4, 1, 0,  0, 3'b000, 0, 0, 1);
    add(1, 1, 1, 3'b000, 0, 0, 0, 0,  0, 3'b000, 0, 0, 1);   // start outside FSLD ignored
    add(1, 7, 1, 3'b000, 0, 0, 0, 0,  4, 3'b000, 1, 0, 0);
    add(1, 7, 0, 3'b000, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0);

    // Abort during BIAS; start ignored while master is elsewhere; abort beats a same-cycle done.
    add(1, 7, 1, 3'b000, 0, 1, 1, 1,  1, 3'b100, 0, 0, 0);
    add(1, 7, 0, 3'b000, 1, 1, 1, 1,  1, 3'b000, 0, 1, 0);
    add(1, 7, 0, 3'b100, 0, 1, 1, 1,  2, 3'b010, 0, 0, 0);
    add(1, 7, 0, 3'b000, 1, 1, 1, 1,  2, 3'b000, 0, 1, 0);
    add(1, 1, 0, 3'b000, 0, 1, 1, 1,  0, 3'b000, 0, 0, 0);
    add(1, 1, 1, 3'b000, 0, 1, 1, 1,  0, 3'b000, 0, 0, 0);
    add(1, 7, 0, 3'b000, 0, 1, 1, 1,  0, 3'b000, 0, 0, 0);
    add(1, 7, 1, 3'b000, 0, 1, 1, 1,  1, 3'b100, 0, 0, 0);
    add(1, 1, 0, 3'b100, 0, 1, 1, 1,  0, 3'b000, 0, 0, 0);

    // Stray dones and a start mid-load change nothing; done with the start cycle is ignored.
    add(1, 7, 1, 3'b100, 0, 2, 2, 2,  1, 3'b100, 0, 0, 0);
    add(1, 7, 0, 3'b001, 0, 2, 2, 2,  1, 3'b000, 0, 0, 0);
    add(1, 7, 0, 3'b010, 0, 2, 2, 2,  1, 3'b000, 0, 0, 0);
    for (int n = 0; n < 2; n++) add(1, 7, 0, 3'b000, 1, 2, 2, 2,  1, 3'b000, 0, 16'(n + 1), 0);
    add(1, 7, 0, 3'b100, 0, 2, 2, 2,  2, 3'b010, 0, 0, 0);
    add(1, 7, 1, 3'b000, 0, 2, 2, 2,  2, 3'b000, 0, 0, 0);
    for (int n = 0; n < 2; n++) add(1, 7, 0, 3'b000, 1, 2, 2, 2,  2, 3'b000, 0, 16'(n + 1), 0);
    add(1, 7, 0, 3'b010, 0, 2, 2, 2,  3, 3'b001, 0, 0, 0);
    for (int n = 0; n < 2; n++) add(1, 7, 0, 3'b000, 1, 2, 2, 2,  3, 3'b000, 0, 16'(n + 1), 0);
    add(1, 7, 0, 3'b001, 0, 2, 2, 2,  4, 3'b000, 1, 0, 0);
    add(1, 7, 0, 3'b000, 0, 2, 2, 2,  0, 3'b000, 0, 0, 0);

    // Reset in IF with beat_cnt=5 and a pending error.
    add(1, 7, 1, 3'b000, 0, 2, 1, 9,  1, 3'b100, 0, 0, 0);
    add(1, 7, 0, 3'b000, 1, 2, 1, 9,  1, 3'b000, 0, 1, 0);
    add(1, 7, 0, 3'b100, 0, 2, 1, 9,  2, 3'b010, 0, 0, 1);
    add(1, 7, 0, 3'b000, 1, 2, 1, 9,  2, 3'b000, 0, 1, 1);
    add(1, 7, 0, 3'b010, 0, 2, 1, 9,  3, 3'b001, 0, 0, 1);
    for (int n = 0; n < 5; n++) add(1, 7, 0, 3'b000, 1, 2, 1, 9,  3, 3'b000, 0, 16'(n + 1), 1);
    add(0, 7, 0, 3'b001, 1, 2, 1, 9,  0, 3'b000, 0, 0, 0);
    add(1, 7, 0, 3'b000, 0, 2, 1, 9,  0, 3'b000, 0, 0, 0);

    foreach (vq[k]) apply(vq[k]);

    // Beat counter saturation: 65536 beats against a 65535-word kernel, no error.
    apply(mk(1, 7, 1, 3'b000, 0, 16'hFFFF, 0, 0,  1, 3'b100, 0, 0, 0));
    for (int n = 0; n < 65536; n++)
      apply(mk(1, 7, 0, 3'b000, 1, 16'hFFFF, 0, 0,  1, 3'b000, 0, (n >= 65535) ? 16'hFFFF : 16'(n + 1), 0));
    apply(mk(1, 7, 0, 3'b100, 1, 16'hFFFF, 0, 0,  4, 3'b000, 1, 0, 0));
    apply(mk(1, 7, 0, 3'b000, 0, 16'hFFFF, 0, 0,  0, 3'b000, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
